// File: rtl/conv_tile_sched.sv
// Layer tile scheduler: per tile runs load -> compute -> store via start/done handshakes.
// Optional CONV_PERF_CNT_EN adds the perf_cycles busy-cycle counter port.
module conv_tile_sched #(
    parameter int AW = 16,
    parameter int CW = 24,
    parameter int N  = 128,
    parameter int M  = 256,
    parameter int R  = 128,
    parameter int C  = 128,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int K  = 3,
    parameter int S  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_start,
    input  logic          conv_abort,
    output logic          conv_busy,
    output logic          conv_done,
    output logic          load_start,
    input  logic          load_done,
    output logic          compute_start,
    input  logic          compute_done,
    output logic          store_start,
    input  logic          store_done,
    output logic          conv_tile_done,
`ifdef CONV_PERF_CNT_EN
    output logic [31:0]   perf_cycles,
`endif
    output logic [CW-1:0] tile_cnt
);

    localparam int ROW_STEP = ((Tr + S - K) / S) * S;
    localparam int COL_STEP = ((Tc + S - K) / S) * S;
    localparam int R_STEP   = ((R + S - K) / S) * S;
    localparam int C_STEP   = ((C + S - K) / S) * S;
    localparam int NT_R     = (R_STEP + ROW_STEP - 1) / ROW_STEP;
    localparam int NT_C     = (C_STEP + COL_STEP - 1) / COL_STEP;
    localparam int NT_M     = (M + Tm - 1) / Tm;
    localparam int NT_N     = (N + Tn - 1) / Tn;
    localparam int TILE_NUM = NT_R * NT_C * NT_M * NT_N;
    localparam logic [CW-1:0] LAST_TILE = CW'(TILE_NUM - 1);

    // Elaboration-time sanity check on the configuration.
    if (64'(TILE_NUM) >= (64'd1 << CW) || TILE_NUM < 1 || AW < 1) begin : g_cfg_err
        $error("conv_tile_sched: TILE_NUM does not fit the tile counter");
    end

    typedef enum logic [2:0] {IDLE, LOAD, COMP, STORE, ADV, FIN} state_t;

    state_t        state, state_nxt;
    logic          ls_nxt, cs_nxt, ss_nxt, td_nxt, cd_nxt, busy_nxt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            conv_busy      <= 1'b0;
            conv_done      <= 1'b0;
            load_start     <= 1'b0;
            compute_start  <= 1'b0;
            store_start    <= 1'b0;
            conv_tile_done <= 1'b0;
            tile_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            conv_busy      <= busy_nxt;
            conv_done      <= cd_nxt;
            load_start     <= ls_nxt;
            compute_start  <= cs_nxt;
            store_start    <= ss_nxt;
            conv_tile_done <= td_nxt;
            tile_cnt       <= cnt_nxt;
        end
    end

    // The start pulse register doubles as the "first cycle in state" flag,
    // so a done arriving alongside its own start pulse is ignored.
    always_comb begin
        state_nxt = state;
        ls_nxt    = 1'b0;
        cs_nxt    = 1'b0;
        ss_nxt    = 1'b0;
        td_nxt    = 1'b0;
        cd_nxt    = 1'b0;
        cnt_nxt   = tile_cnt;
        case (state)
            IDLE: if (conv_start) begin
                state_nxt = LOAD;
                ls_nxt    = 1'b1;
                cnt_nxt   = '0;
            end
            LOAD: if (!load_start && load_done) begin
                state_nxt = COMP;
                cs_nxt    = 1'b1;
            end
            COMP: if (!compute_start && compute_done) begin
                state_nxt = STORE;
                ss_nxt    = 1'b1;
            end
            STORE: if (!store_start && store_done) begin
                state_nxt = ADV;
                td_nxt    = 1'b1;
            end
            ADV: begin
                cnt_nxt = tile_cnt + 1'b1;
                if (tile_cnt == LAST_TILE) begin
                    state_nxt = FIN;
                    cd_nxt    = 1'b1;
                end else begin
                    state_nxt = LOAD;
                    ls_nxt    = 1'b1;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything and freezes the tile count.
        if (state != IDLE && conv_abort) begin
            state_nxt = IDLE;
            ls_nxt    = 1'b0;
            cs_nxt    = 1'b0;
            ss_nxt    = 1'b0;
            td_nxt    = 1'b0;
            cd_nxt    = 1'b0;
            cnt_nxt   = tile_cnt;
        end
        busy_nxt = (state_nxt != IDLE);
    end

`ifdef CONV_PERF_CNT_EN
    // Value visible in a cycle includes that cycle, so it reads the full count at conv_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_cycles <= '0;
        else if (state == IDLE && conv_start)
            perf_cycles <= 32'd1;
        else if (busy_nxt && perf_cycles != 32'hFFFF_FFFF)
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched (small config, TILE_NUM=2), schedule-based reference model.
module tb_conv_tile_sched;

    localparam int CW = 24;
    localparam int TN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          conv_start, conv_abort;
    logic          load_done, compute_done, store_done;
    logic          conv_busy, conv_done, load_start, compute_start, store_start, conv_tile_done;
    logic [CW-1:0] tile_cnt;
`ifdef CONV_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int last_cnt = 0;

    conv_tile_sched #(
        .AW(16), .CW(CW), .N(16), .M(32), .R(18), .C(18),
        .Tn(16), .Tm(16), .Tr(18), .Tc(18), .K(3), .S(1)
    ) dut (
        .clk(clk), .rst(rst),
        .conv_start(conv_start), .conv_abort(conv_abort),
        .conv_busy(conv_busy), .conv_done(conv_done),
        .load_start(load_start), .load_done(load_done),
        .compute_start(compute_start), .compute_done(compute_done),
        .store_start(store_start), .store_done(store_done),
        .conv_tile_done(conv_tile_done),
`ifdef CONV_PERF_CNT_EN
        .perf_cycles(perf_cycles),
`endif
        .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {conv_busy, load_start, compute_start, store_start, conv_tile_done, conv_done};
    endfunction

    task automatic clr_in();
        conv_start   = 1'b0;
        conv_abort   = 1'b0;
        load_done    = 1'b0;
        compute_done = 1'b0;
        store_done   = 1'b0;
    endtask

    // One layer. The expected timeline is derived arithmetically from the engine delays:
    // start pulse one cycle after entering a phase, next phase one cycle after its done,
    // conv_tile_done one cycle after store_done, conv_done one cycle after the last tile.
    task automatic run_layer(input int dly, input bit early, input bit stray, input bit spam,
                             input bit start_abort, input int abort_tile);
        int dl[TN], dc[TN], ds[TN];
        int ls[TN], ld[TN], cs[TN], cd[TN], ss[TN], sd[TN], td[TN];
        int t, fin, a, last_busy, e_cnt;
        logic [5:0] e;
        for (int i = 0; i < TN; i++) begin
            dl[i] = (dly != 0) ? dly : int'($urandom_range(4, 1));
            dc[i] = (dly != 0) ? dly : int'($urandom_range(4, 1));
            ds[i] = (dly != 0) ? dly : int'($urandom_range(4, 1));
        end
        if (abort_tile >= 0 && ds[abort_tile] < 3) ds[abort_tile] = 3;
        t = 0;
        for (int i = 0; i < TN; i++) begin
            ls[i] = t + 1;      ld[i] = ls[i] + dl[i];
            cs[i] = ld[i] + 1;  cd[i] = cs[i] + dc[i];
            ss[i] = cd[i] + 1;  sd[i] = ss[i] + ds[i];
            td[i] = sd[i] + 1;  t = td[i];
        end
        fin       = t + 1;
        a         = (abort_tile >= 0) ? ss[abort_tile] + 1 : 32'h3fff_ffff;
        last_busy = (abort_tile >= 0) ? a : fin;

        chk("idle_outs", 64'(outs()), 64'd0);
        chk("idle_cnt", 64'(tile_cnt), 64'(last_cnt));
        conv_start = 1'b1;
        conv_abort = start_abort;

        e_cnt = 0;
        for (int r = 1; r <= last_busy + 2; r++) begin
            step();
            clr_in();
            e = '0;
            e[5] = (r <= last_busy);
            e[0] = (abort_tile < 0 && r == fin);
            e_cnt = 0;
            for (int i = 0; i < TN; i++) begin
                if (r <= a) begin
                    if (ls[i] == r) e[4] = 1'b1;
                    if (cs[i] == r) e[3] = 1'b1;
                    if (ss[i] == r) e[2] = 1'b1;
                    if (td[i] == r) e[1] = 1'b1;
                end
                if (td[i] < r && td[i] <= a) e_cnt++;
            end
            chk($sformatf("outs_r%0d", r), 64'(outs()), 64'(e));
            chk($sformatf("tile_cnt_r%0d", r), 64'(tile_cnt), 64'(e_cnt));
`ifdef CONV_PERF_CNT_EN
            chk($sformatf("perf_r%0d", r), 64'(perf_cycles), 64'((r < last_busy) ? r : last_busy));
`endif
            if (r > a) continue;
            for (int i = 0; i < TN; i++) begin
                if (stray) begin
                    if (r > ls[i] && r < ld[i]) {compute_done, store_done} = 2'($urandom);
                    if (r > cs[i] && r < cd[i]) {load_done, store_done}    = 2'($urandom);
                    if (r > ss[i] && r < sd[i]) {load_done, compute_done}  = 2'($urandom);
                    if (r == td[i] || r == fin)
                        {load_done, compute_done, store_done} = 3'($urandom);
                end
                if (early) begin
                    if (r == ls[i]) load_done    = 1'b1;
                    if (r == cs[i]) compute_done = 1'b1;
                    if (r == ss[i]) store_done   = 1'b1;
                end
                if (r == ld[i]) load_done    = 1'b1;
                if (r == cd[i]) compute_done = 1'b1;
                if (r == sd[i]) store_done   = 1'b1;
            end
            if (spam && r <= last_busy) conv_start = 1'($urandom);
            if (r == a) conv_abort = 1'b1;
        end
        clr_in();
        last_cnt = e_cnt;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        step();
        step();
        chk("reset_outs", 64'(outs()), 64'd0);
        chk("reset_cnt", 64'(tile_cnt), 64'd0);
        rst = 1'b0;
        step();
        chk("post_reset_outs", 64'(outs()), 64'd0);

        // Abort while idle must not wake the scheduler.
        conv_abort = 1'b1;
        step();
        conv_abort = 1'b0;
        step();
        chk("idle_abort_noop", 64'(outs()), 64'd0);

        run_layer(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);   // zero-wait engines
        run_layer(5, 1'b1, 1'b0, 1'b0, 1'b0, -1);   // done in pulse cycle ignored
        run_layer(4, 1'b0, 1'b1, 1'b0, 1'b0, -1);   // foreign dones ignored
        run_layer(0, 1'b0, 1'b0, 1'b0, 1'b0, 1);    // abort during 2nd STORE
        run_layer(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);   // fresh layer after abort
        run_layer(0, 1'b0, 1'b1, 1'b1, 1'b1, -1);   // start spam, start+abort in idle
        run_layer(3, 1'b0, 1'b0, 1'b0, 1'b0, -1);   // 3-cycle engines (perf = 27)

        // Async reset in COMP drops everything immediately.
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        chk("rst_seq_load_start", 64'(load_start), 64'd1);
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("rst_seq_compute_start", 64'(compute_start), 64'd1);
        step();
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 64'(outs()), 64'd0);
        chk("async_rst_cnt", 64'(tile_cnt), 64'd0);
`ifdef CONV_PERF_CNT_EN
        chk("async_rst_perf", 64'(perf_cycles), 64'd0);
`endif
        step();
        rst = 1'b0;
        step();
        chk("post_async_rst_outs", 64'(outs()), 64'd0);
        last_cnt = 0;

        for (int k = 0; k < 6; k++)
            run_layer(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(2, 0) == 0) ? int'($urandom_range(TN - 1, 0)) : -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
